nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that feeds one 4-bit ripple-carry slice, one nibble per cycle, and consumes the slice's sum and carry. The carry is registered between slices. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area: a WIDTH-bit add uses one 4-bit adder instance instead of WIDTH/4 instances.

---
 rtl/nibble_serial_adder_pkg.sv | 20 ++
 rtl/nibble_serial_adder_adder4.sv | 31 +++
 rtl/nibble_serial_adder.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder and its 4-bit slice.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int nibbles_of(input int width);
      return width / NIBBLE_W;
   endfunction

   function automatic bit width_ok(input int width);
      return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// Combinational 4-bit ripple-carry adder slice; clock/reset exist only for interface compatibility.
module Adder4Bit
   import nibble_serial_adder_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] c;
   logic              unused_clk_rst;

   assign unused_clk_rst = &{1'b0, clock, reset};

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < NIBBLE_W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, with valid/ready on both sides.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int NIBBLES = nibbles_of(WIDTH);
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [WIDTH-1:0]    opa_q, opb_q, res_q, res_d;
   logic                carry_q;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic                last_nibble;

   Adder4Bit u_slice (
      .clock (clock),
      .reset (reset),
      .a     (opa_q[NIBBLE_W-1:0]),
      .b     (opb_q[NIBBLE_W-1:0]),
      .cin   (carry_q),
      .sum   (slice_sum),
      .cout  (slice_cout)
   );

   assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));
   // Each slice sum enters at the MSB end, so after NIBBLES shifts nibble 0 sits at the LSB.
   assign res_d = (res_q >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)    state_d = RUN;
         RUN:     if (last_nibble) state_d = DONE;
         DONE:    if (out_ready)   state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         out_sum  <= '0;
         out_cout <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               opa_q   <= in_x;
               opb_q   <= in_y;
               carry_q <= in_cin;
               cnt_q   <= '0;
            end
            RUN: begin
               opa_q   <= opa_q >> NIBBLE_W;
               opb_q   <= opb_q >> NIBBLE_W;
               res_q   <= res_d;
               carry_q <= slice_cout;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_nibble) begin
                  out_sum  <= res_d;
                  out_cout <= slice_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

   logic        clock = 1'b0;
   logic        reset;
   logic        iv, ir, cin, ov, ordy, cout;
   logic [15:0] x, y, sum;
   logic        iv4, ir4, cin4, ov4, ordy4, cout4;
   logic [3:0]  x4, y4, sum4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clock(clock), .reset(reset), .in_valid(iv), .in_ready(ir), .in_x(x), .in_y(y),
      .in_cin(cin), .out_valid(ov), .out_ready(ordy), .out_sum(sum), .out_cout(cout)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clock(clock), .reset(reset), .in_valid(iv4), .in_ready(ir4), .in_x(x4), .in_y(y4),
      .in_cin(cin4), .out_valid(ov4), .out_ready(ordy4), .out_sum(sum4), .out_cout(cout4)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents one operand pair and returns #1 after the accept edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
      iv = 1'b1; x = a; y = b; cin = c;
      for (int k = 0; k < 20 && !ir; k++) tick();
      n_checks++;
      if (ir !== 1'b1) begin
         $display("FAIL send_ready_timeout: in_ready=%b required 1", ir);
         n_fail++;
      end
      tick();
      iv = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_checks += 4;
      if (ir !== 1'b1)    begin $display("FAIL rst_in_ready: got %b want 1", ir); n_fail++; end
      if (ov !== 1'b0)    begin $display("FAIL rst_out_valid: got %b want 0", ov); n_fail++; end
      if (sum !== 16'h0)  begin $display("FAIL rst_out_sum: got %h want 0000", sum); n_fail++; end
      if (cout !== 1'b0)  begin $display("FAIL rst_out_cout: got %b want 0", cout); n_fail++; end
      n_checks += 2;
      if (ir4 !== 1'b1)   begin $display("FAIL rst4_in_ready: got %b want 1", ir4); n_fail++; end
      if (ov4 !== 1'b0)   begin $display("FAIL rst4_out_valid: got %b want 0", ov4); n_fail++; end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      ordy = 1'b1;
      send(16'h1234, 16'h4321, 1'b0);
      n_checks += 2;
      if (ov !== 1'b0) begin $display("FAIL basic_valid_a0: got %b want 0", ov); n_fail++; end
      if (ir !== 1'b0) begin $display("FAIL basic_ready_a0: got %b want 0", ir); n_fail++; end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks += 2;
         if (ov !== 1'b0) begin $display("FAIL basic_valid_early: cyc %0d got %b want 0", i, ov); n_fail++; end
         if (ir !== 1'b0) begin $display("FAIL basic_ready_run: cyc %0d got %b want 0", i, ir); n_fail++; end
      end
      tick();
      n_checks += 4;
      if (ov !== 1'b1)      begin $display("FAIL basic_valid: got %b want 1", ov); n_fail++; end
      if (sum !== 16'h5555) begin $display("FAIL basic_sum: got %h want 5555", sum); n_fail++; end
      if (cout !== 1'b0)    begin $display("FAIL basic_cout: got %b want 0", cout); n_fail++; end
      if (ir !== 1'b0)      begin $display("FAIL basic_ready_done: got %b want 0", ir); n_fail++; end
      tick();
      n_checks += 3;
      if (ov !== 1'b0)      begin $display("FAIL basic_valid_drop: got %b want 0", ov); n_fail++; end
      if (ir !== 1'b1)      begin $display("FAIL basic_ready_back: got %b want 1", ir); n_fail++; end
      if (sum !== 16'h5555) begin $display("FAIL basic_sum_hold: got %h want 5555", sum); n_fail++; end
   endtask

   task automatic test_carry_chain();
      ordy = 1'b1;
      send(16'hFFFF, 16'h0000, 1'b1);
      repeat (4) tick();
      n_checks += 3;
      if (ov !== 1'b1)      begin $display("FAIL carry_valid: got %b want 1", ov); n_fail++; end
      if (sum !== 16'h0000) begin $display("FAIL carry_sum: got %h want 0000", sum); n_fail++; end
      if (cout !== 1'b1)    begin $display("FAIL carry_cout: got %b want 1", cout); n_fail++; end
      tick();
   endtask

   task automatic test_backpressure();
      ordy = 1'b0;
      send(16'h8000, 16'h8000, 1'b0);
      repeat (4) tick();
      n_checks += 3;
      if (ov !== 1'b1)      begin $display("FAIL bp_valid: got %b want 1", ov); n_fail++; end
      if (sum !== 16'h0000) begin $display("FAIL bp_sum: got %h want 0000", sum); n_fail++; end
      if (cout !== 1'b1)    begin $display("FAIL bp_cout: got %b want 1", cout); n_fail++; end
      iv = 1'b1; x = 16'h0001; y = 16'h0000; cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks += 4;
         if (ov !== 1'b1)      begin $display("FAIL bp_valid_hold: cyc %0d got %b want 1", i, ov); n_fail++; end
         if (sum !== 16'h0000) begin $display("FAIL bp_sum_hold: cyc %0d got %h want 0000", i, sum); n_fail++; end
         if (cout !== 1'b1)    begin $display("FAIL bp_cout_hold: cyc %0d got %b want 1", i, cout); n_fail++; end
         if (ir !== 1'b0)      begin $display("FAIL bp_ready_done: cyc %0d got %b want 0", i, ir); n_fail++; end
      end
      iv = 1'b0;
      ordy = 1'b1;
      tick();
      n_checks += 3;
      if (ov !== 1'b0)      begin $display("FAIL bp_valid_drop: got %b want 0", ov); n_fail++; end
      if (ir !== 1'b1)      begin $display("FAIL bp_ready_back: got %b want 1", ir); n_fail++; end
      if (sum !== 16'h0000) begin $display("FAIL bp_sum_keep: got %h want 0000", sum); n_fail++; end
      tick();
      n_checks++;
      if (ir !== 1'b1) begin $display("FAIL bp_no_phantom_accept: got %b want 1", ir); n_fail++; end
   endtask

   task automatic test_back_to_back();
      int          acc_cyc [2];
      logic [15:0] res [2];
      int          nacc = 0;
      int          nres = 0;
      logic        accept_now;
      ordy = 1'b1;
      iv = 1'b1; x = 16'h0001; y = 16'h0001; cin = 1'b0;
      for (int c = 0; c < 30 && nres < 2; c++) begin
         accept_now = iv && ir;
         tick();
         if (accept_now && nacc < 2) begin
            acc_cyc[nacc] = c;
            nacc++;
            if (nacc == 1) begin x = 16'h0010; y = 16'h0010; end
            else iv = 1'b0;
         end
         if (ov === 1'b1 && nres < 2) begin
            res[nres] = sum;
            nres++;
         end
      end
      iv = 1'b0;
      n_checks++;
      if (nres != 2 || nacc != 2) begin
         $display("FAIL b2b_timeout: results %0d accepts %0d required 2 and 2", nres, nacc);
         n_fail++;
      end else begin
         n_checks += 3;
         if (res[0] !== 16'h0002) begin $display("FAIL b2b_sum0: got %h want 0002", res[0]); n_fail++; end
         if (res[1] !== 16'h0020) begin $display("FAIL b2b_sum1: got %h want 0020", res[1]); n_fail++; end
         if (acc_cyc[1] - acc_cyc[0] != 6) begin
            $display("FAIL b2b_interval: got %0d want 6", acc_cyc[1] - acc_cyc[0]); n_fail++;
         end
      end
      tick();
   endtask

   task automatic test_reset_abort();
      ordy = 1'b1;
      send(16'h00FF, 16'h0001, 1'b0);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks += 4;
      if (ir !== 1'b1)      begin $display("FAIL abort_ready: got %b want 1", ir); n_fail++; end
      if (ov !== 1'b0)      begin $display("FAIL abort_valid: got %b want 0", ov); n_fail++; end
      if (sum !== 16'h0000) begin $display("FAIL abort_sum: got %h want 0000", sum); n_fail++; end
      if (cout !== 1'b0)    begin $display("FAIL abort_cout: got %b want 0", cout); n_fail++; end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (ov !== 1'b0) begin $display("FAIL abort_no_result: cyc %0d got %b want 0", i, ov); n_fail++; end
      end
      send(16'h0002, 16'h0003, 1'b0);
      repeat (4) tick();
      n_checks += 3;
      if (ov !== 1'b1)      begin $display("FAIL abort_next_valid: got %b want 1", ov); n_fail++; end
      if (sum !== 16'h0005) begin $display("FAIL abort_next_sum: got %h want 0005", sum); n_fail++; end
      if (cout !== 1'b0)    begin $display("FAIL abort_next_cout: got %b want 0", cout); n_fail++; end
      tick();
   endtask

   task automatic test_width4();
      ordy4 = 1'b1;
      iv4 = 1'b1; x4 = 4'h9; y4 = 4'h8; cin4 = 1'b1;
      n_checks++;
      if (ir4 !== 1'b1) begin $display("FAIL w4_ready: got %b want 1", ir4); n_fail++; end
      tick();
      iv4 = 1'b0;
      n_checks++;
      if (ov4 !== 1'b0) begin $display("FAIL w4_valid_a0: got %b want 0", ov4); n_fail++; end
      tick();
      n_checks += 3;
      if (ov4 !== 1'b1)   begin $display("FAIL w4_valid: got %b want 1", ov4); n_fail++; end
      if (sum4 !== 4'h2)  begin $display("FAIL w4_sum: got %h want 2", sum4); n_fail++; end
      if (cout4 !== 1'b1) begin $display("FAIL w4_cout: got %b want 1", cout4); n_fail++; end
      tick();
      n_checks++;
      if (ov4 !== 1'b0) begin $display("FAIL w4_valid_drop: got %b want 0", ov4); n_fail++; end
   endtask

   initial begin
      reset = 1'b1;
      iv = 1'b0; x = '0; y = '0; cin = 1'b0; ordy = 1'b0;
      iv4 = 1'b0; x4 = '0; y4 = '0; cin4 = 1'b0; ordy4 = 1'b0;
      test_reset();
      test_basic();
      test_carry_chain();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_width4();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
